// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with exception redirect, jumps, branches and a return-address stack
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                INC       = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 'h10,
  parameter int                J_W       = 26,
  parameter int                B_W       = 16,
  parameter int                BR_REL    = 1,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exc,
  input  logic              ret,
  input  logic              call,
  input  logic              j_label,
  input  logic [J_W-1:0]    j_address,
  input  logic              b_label,
  input  logic              zero,
  input  logic [B_W-1:0]    b_address,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] epc_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, epc_q, seq, jt, bt, b_ext;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_inc, top_dec;
  logic [CNT_W-1:0]  cnt_q;
  logic              uf_q, do_push, do_pop, do_uf, epc_cap;

  assign seq = pc_q + ADDR_W'(INC);

  if (J_W >= ADDR_W) begin : g_jt_trunc
    assign jt = j_address[ADDR_W-1:0];
  end else begin : g_jt_ext
    assign jt = {{(ADDR_W-J_W){1'b0}}, j_address};
  end

  if (B_W >= ADDR_W) begin : g_b_trunc
    assign b_ext = b_address[ADDR_W-1:0];
  end else if (BR_REL != 0) begin : g_b_sext
    assign b_ext = {{(ADDR_W-B_W){b_address[B_W-1]}}, b_address};
  end else begin : g_b_zext
    assign b_ext = {{(ADDR_W-B_W){1'b0}}, b_address};
  end

  if (BR_REL != 0) begin : g_bt_rel
    assign bt = seq + b_ext;
  end else begin : g_bt_abs
    assign bt = b_ext;
  end

  // Circular stack: top_q indexes the newest entry; a push when full overwrites the oldest.
  assign top_inc = (top_q == PTR_W'(RAS_DEPTH-1)) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_W'(RAS_DEPTH-1) : top_q - PTR_W'(1);

  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_underflow = uf_q;
  assign pc_out        = pc_q;
  assign epc_out       = epc_q;

  always_comb begin
    pc_next = seq;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_uf   = 1'b0;
    epc_cap = 1'b0;
    if (exc) begin
      pc_next = EXC_VEC;
      epc_cap = 1'b1;
    end else if (stall) begin
      pc_next = pc_q;
    end else if (ret) begin
      if (!ras_empty) begin
        pc_next = ras_mem[top_q];
        do_pop  = 1'b1;
      end else begin
        do_uf = 1'b1;
      end
    end else if (call) begin
      pc_next = jt;
      do_push = 1'b1;
    end else if (j_label) begin
      pc_next = jt;
    end else if (b_label && zero) begin
      pc_next = bt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
      top_q <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      pc_q <= pc_next;
      uf_q <= do_uf;
      if (epc_cap) epc_q <= pc_q;
      if (do_push) begin
        top_q <= top_inc;
        if (!ras_full) cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop) begin
        top_q <= top_dec;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Entry storage carries no reset; the rst guard keeps a push from landing while reset is held.
  always_ff @(posedge clk) begin
    if (do_push && !rst) ras_mem[top_inc] <= seq;
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed scoreboard bench for pc_unit (default and 8-bit configurations)
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, exc, ret, call, j_label, b_label, zero;
  logic [25:0] j_address;
  logic [15:0] b_address;
  logic [31:0] pc_out, pc_next, epc_out;
  logic        ras_empty, ras_full, ras_underflow;

  logic        rst8, ret8, call8, jl8;
  logic [25:0] ja8;
  logic [7:0]  pc8, pcn8, epc8;
  logic        emp8, full8, uf8;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc), .ret(ret), .call(call),
    .j_label(j_label), .j_address(j_address), .b_label(b_label), .zero(zero),
    .b_address(b_address), .pc_out(pc_out), .pc_next(pc_next), .epc_out(epc_out),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  pc_unit #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst8), .stall(1'b0), .exc(1'b0), .ret(ret8), .call(call8),
    .j_label(jl8), .j_address(ja8), .b_label(1'b0), .zero(1'b0),
    .b_address(16'h0), .pc_out(pc8), .pc_next(pcn8), .epc_out(epc8),
    .ras_empty(emp8), .ras_full(full8), .ras_underflow(uf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic e, s, r, c, j, input logic [25:0] ja,
                     input logic b, z, input logic [15:0] ba);
    exc = e; stall = s; ret = r; call = c; j_label = j; j_address = ja;
    b_label = b; zero = z; b_address = ba;
  endtask

  // Expected PC is queued when the stimulus is applied, popped once the edge has landed.
  task automatic step(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk(tag, pc_out, e);
  endtask

  task automatic step8(input string tag, input logic [7:0] exp);
    logic [31:0] e;
    exp_q.push_back({24'h0, exp});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk(tag, {24'h0, pc8}, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst8 = 1'b1; ret8 = 0; call8 = 0; jl8 = 0; ja8 = '0;
    set(0, 0, 0, 0, 0, 26'h0, 0, 0, 16'h0);
    @(posedge clk); #1;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_epc", epc_out, 32'h0);
    chk("reset_empty", {31'h0, ras_empty}, 32'h1);
    chk("reset_full", {31'h0, ras_full}, 32'h0);
    chk("reset_uf", {31'h0, ras_underflow}, 32'h0);
    rst = 1'b0; rst8 = 1'b0;
    chk("pc_next_comb", pc_next, 32'h1);

    step("seq1", 1); step("seq2", 2); step("seq3", 3);
    #2 rst = 1'b1; #1;
    chk("async_reset", pc_out, 32'h0);
    rst = 1'b0;
    step("post_reset", 1);

    set(0, 0, 0, 0, 1, 26'd8, 0, 0, 16'h0);      step("jmp8", 8);
    set(0, 0, 0, 0, 0, 26'd0, 1, 1, 16'hFFFC);   step("br_back", 5);
    set(0, 0, 0, 0, 1, 26'd8, 0, 0, 16'h0);      step("jmp8b", 8);
    set(0, 0, 0, 0, 0, 26'd0, 1, 0, 16'hFFFC);   step("br_not_taken", 9);
    set(0, 0, 0, 0, 1, 26'h40, 0, 0, 16'h0);     step("jmp40", 32'h40);
    set(0, 0, 0, 0, 1, 26'h80, 1, 1, 16'hFFFC);  step("jmp_over_br", 32'h80);

    set(0, 0, 0, 0, 1, 26'd20, 0, 0, 16'h0);     step("jmp20", 20);
    set(0, 1, 0, 0, 1, 26'h33, 0, 0, 16'h0);
    step("stall1", 20); step("stall2", 20); step("stall3", 20);
    chk("stall_uf", {31'h0, ras_underflow}, 32'h0);
    set(1, 1, 0, 0, 0, 26'd0, 0, 0, 16'h0);      step("exc_vec", 32'h10);
    chk("exc_epc", epc_out, 32'd20);

    set(0, 0, 0, 0, 1, 26'd10, 0, 0, 16'h0);     step("jmp10", 10);
    set(0, 0, 0, 1, 0, 26'h100, 0, 0, 16'h0);    step("call100", 32'h100);
    chk("call_empty", {31'h0, ras_empty}, 32'h0);
    set(0, 0, 1, 0, 0, 26'd0, 0, 0, 16'h0);      step("ret11", 11);
    chk("ret_empty", {31'h0, ras_empty}, 32'h1);

    set(0, 0, 0, 0, 1, 26'd1, 0, 0, 16'h0);      step("jmp1", 1);
    set(0, 0, 0, 1, 0, 26'd2, 0, 0, 16'h0);      step("ncall_a", 2);
    set(0, 0, 0, 1, 0, 26'd3, 0, 0, 16'h0);      step("ncall_b", 3);
    set(0, 0, 0, 1, 0, 26'h50, 0, 0, 16'h0);     step("ncall_c", 32'h50);
    set(0, 0, 1, 0, 0, 26'd0, 0, 0, 16'h0);
    step("nret4", 4); step("nret3", 3); step("nret2", 2);

    set(0, 0, 0, 0, 1, 26'd1, 0, 0, 16'h0);      step("ojmp1", 1);
    set(0, 0, 0, 1, 0, 26'd2, 0, 0, 16'h0);      step("ocall1", 2);
    set(0, 0, 0, 1, 0, 26'd3, 0, 0, 16'h0);      step("ocall2", 3);
    set(0, 0, 0, 1, 0, 26'd4, 0, 0, 16'h0);      step("ocall3", 4);
    chk("not_full_3", {31'h0, ras_full}, 32'h0);
    set(0, 0, 0, 1, 0, 26'd5, 0, 0, 16'h0);      step("ocall4", 5);
    chk("full_4", {31'h0, ras_full}, 32'h1);
    set(0, 0, 0, 1, 0, 26'h60, 0, 0, 16'h0);     step("ocall5", 32'h60);
    chk("full_5", {31'h0, ras_full}, 32'h1);
    set(0, 0, 1, 0, 0, 26'd0, 0, 0, 16'h0);
    step("oret6", 6); step("oret5", 5); step("oret4", 4); step("oret3", 3);
    chk("oret_empty", {31'h0, ras_empty}, 32'h1);
    chk("no_uf_yet", {31'h0, ras_underflow}, 32'h0);
    step("uf_ret", 4);
    chk("uf_pulse", {31'h0, ras_underflow}, 32'h1);
    set(0, 0, 0, 0, 0, 26'd0, 0, 0, 16'h0);      step("uf_after", 5);
    chk("uf_clear", {31'h0, ras_underflow}, 32'h0);

    jl8 = 1; ja8 = 26'hFF;                        step8("w_jmpff", 8'hFF);
    jl8 = 0;                                      step8("w_wrap", 8'h00);
    call8 = 1; ja8 = 26'h20;                      step8("w_call20", 8'h20);
    ja8 = 26'h30;                                 step8("w_call30", 8'h30);
    ret8 = 1; ja8 = 26'h40;                       step8("w_retcall", 8'h21);
    chk("w_not_empty", {31'h0, emp8}, 32'h0);
    call8 = 0;                                    step8("w_ret1", 8'h01);
    chk("w_empty", {31'h0, emp8}, 32'h1);
    chk("w_uf", {31'h0, uf8}, 32'h0);
    ret8 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit that replaces the single-width PC register at the head of the fetch stage. It generates the next instruction address and supports stall, exception redirect with EPC capture, absolute jumps, branches in relative or absolute mode, and call/return through an internal return-address stack (RAS). All control inputs come from decode and execute. `pc_out` drives instruction-memory addressing.

## Interface
Parameters:
- ADDR_W, 32, PC width.
- INC, 1, sequential increment; the memory is word-addressed, so the default is 1.
- RESET_PC, 0, PC value after reset.
- EXC_VEC, 'h10, exception handler address.
- J_W, 26, jump target field width.
- B_W, 16, branch field width.
- BR_REL, 1, branch mode. 1 = PC-relative with sign-extended offset. 0 = absolute with zero-extended address.
- RAS_DEPTH, 4, number of return-stack entries; must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold the PC and the RAS.
- exc  in  1  exception redirect.
- ret  in  1  return: pop the RAS.
- call  in  1  call: push the return address, then jump to j_address.
- j_label  in  1  absolute jump.
- j_address  in  J_W  jump/call target.
- b_label  in  1  branch instruction.
- zero  in  1  branch condition; the branch is taken when b_label && zero.
- b_address  in  B_W  branch offset (BR_REL=1) or target (BR_REL=0).
- pc_out  out  ADDR_W  current PC (registered).
- pc_next  out  ADDR_W  combinational value the PC will load at the next edge.
- epc_out  out  ADDR_W  PC captured at the last exception (registered).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_underflow  out  1  one-cycle registered pulse.

## Operation
Derived values:
- seq = pc_out + INC, modulo 2^ADDR_W.
- jt = j_address zero-extended to ADDR_W, or truncated if J_W > ADDR_W.
- bt:
  - BR_REL=1: seq + sign-extended b_address, modulo 2^ADDR_W.
  - BR_REL=0: b_address zero-extended.

pc_next priority (highest first). Exactly one action is taken per cycle.
1. exc: pc_next = EXC_VEC. epc_out <= pc_out. RAS unchanged. Overrides stall.
2. stall: pc_next = pc_out. RAS and epc_out unchanged.
3. ret:
   - RAS not empty: pc_next = top entry; pop.
   - RAS empty: pc_next = seq; ras_underflow pulses the next cycle.
4. call: pc_next = jt; push seq.
   - If the RAS is full, the oldest entry is discarded. Count stays RAS_DEPTH; ras_full stays 1.
5. j_label: pc_next = jt.
6. b_label && zero: pc_next = bt.
7. Otherwise: pc_next = seq.

RAS structure:
- Circular buffer with a top pointer and a saturating count from 0 to RAS_DEPTH.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are combinational from registered count.
- Pop then push in consecutive cycles returns the LIFO order.
- After an overflow, only the newest RAS_DEPTH entries are retrievable. Further pops beyond those underflow.

Other rules:
- ret and call asserted together: ret wins and no push occurs.
- A lower-priority request that is not taken is dropped. It is not queued.
- ras_underflow is 1 only in the cycle after an underflowing ret. It is otherwise 0, including during stall.

## Timing
- Reset (asynchronous, takes effect immediately and is held while rst=1):
  - pc_out = RESET_PC, epc_out = 0.
  - RAS count = 0: ras_empty=1, ras_full=0, ras_underflow=0.
  - RAS entry contents are don't-care.
- Reset asserted mid-operation overrides every input in the same cycle. No pending push, pop or epc capture completes.
- The first rising edge after rst deasserts performs a normal pc_next update.
- pc_next is valid combinationally in the same cycle as its inputs. pc_out reflects it one cycle later, so redirect latency is 1 cycle.
- epc_out updates on the same edge that loads EXC_VEC.
- The RAS pop/push takes effect on the same edge as the PC update. The count and flags reflect it the following cycle.
- Wrap-around: pc_out = 2^ADDR_W−INC followed by a sequential step gives 0. Relative branches wrap the same way.

## Test plan
- Reset and sequential stepping, defaults:
  - rst pulse gives pc_out=0.
  - 3 idle cycles give 1, 2, 3.
  - Assert rst asynchronously mid-cycle: pc_out returns to 0 before the next edge.
- Jump and branch, BR_REL=1, at pc_out=8:
  - b_label=1, zero=1, b_address=16'hFFFC gives pc_out=5.
  - zero=0 gives 9.
  - j_label with j_address=26'h40 gives 'h40.
  - j_label and a taken branch in the same cycle: the jump wins.
- Stall and exception:
  - stall for 3 cycles at pc=20: pc_out holds 20.
  - exc while stalled gives pc_out='h10 and epc_out=20 on the next edge.
- RAS, RAS_DEPTH=4:
  - Call from pc=10 to 'h100 gives ras_empty=0.
  - ret gives pc_out=11 and ras_empty=1.
  - Nested calls from pc=1, 2, 3 then 3 rets return to 4, 3, 2 in order.
- RAS overflow/underflow:
  - 5 calls from pc values 1 through 5 leave ras_full=1.
  - 4 rets give 6, 5, 4, 3.
  - A 5th ret at pc=P gives pc_out=P+1 and ras_underflow=1 for exactly one cycle.
- Wrap and priority, ADDR_W=8:
  - pc=255 with a sequential step gives 0.
  - ret and call together with a non-empty RAS: pop only, count decreases by 1.
